// File: rtl/div_ctrl.sv
// Execute-stage sequencer for the multi-cycle divider. It launches DIV/DIVU operands into the divider
// core, stalls execute until the result returns, and drains results that a flush has orphaned.
module div_ctrl #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          es_valid,
   input  logic          es_div_op,
   input  logic          es_div_signed,
   input  logic [DW-1:0] es_src1,
   input  logic [DW-1:0] es_src2,
   input  logic          exc_flush,
   output logic          div_block,
   output logic          div_in_valid,
   input  logic          div_in_ready,
   output logic          div_signed,
   output logic [DW-1:0] div_dividend,
   output logic [DW-1:0] div_divisor,
   input  logic          div_out_valid,
   input  logic [DW-1:0] div_quotient,
   input  logic [DW-1:0] div_remainder,
   output logic          div_res_valid,
   output logic [DW-1:0] div_lo,
   output logic [DW-1:0] div_hi
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

   state_t state_reg;
   logic   done_reg;
   logic   new_div;

   assign new_div = es_valid & es_div_op & ~exc_flush;

   // A divide that arrives during DRAIN is stalled here and only launched once back in IDLE.
   assign div_block = ~exc_flush & (((state_reg == IDLE) & new_div) |
                                    (state_reg == REQ) |
                                    (state_reg == WAIT) |
                                    ((state_reg == DRAIN) & es_valid & es_div_op));

   assign div_res_valid = done_reg & ~exc_flush;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         done_reg     <= 1'b0;
         div_in_valid <= 1'b0;
         div_signed   <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         div_lo       <= '0;
         div_hi       <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (new_div) begin
                  div_dividend <= es_src1;
                  div_divisor  <= es_src2;
                  div_signed   <= es_div_signed;
                  div_in_valid <= 1'b1;
                  state_reg    <= REQ;
               end
            end
            REQ: begin
               if (exc_flush) begin
                  // Once the core has taken the operands its result must still be drained.
                  div_in_valid <= 1'b0;
                  state_reg    <= div_in_ready ? DRAIN : IDLE;
               end else if (div_in_ready) begin
                  div_in_valid <= 1'b0;
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (div_out_valid && !exc_flush) begin
                  div_lo    <= div_quotient;
                  div_hi    <= div_remainder;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else if (div_out_valid) begin
                  state_reg <= IDLE;
               end else if (exc_flush) begin
                  state_reg <= DRAIN;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            DRAIN: begin
               if (div_out_valid) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               done_reg     <= 1'b0;
               div_in_valid <= 1'b0;
               state_reg    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a fixed-latency divider core model plus a result scoreboard.
module tb_div_ctrl;
   localparam int DW = 32;
   localparam int L  = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          es_valid, es_div_op, es_div_signed;
   logic [DW-1:0] es_src1, es_src2;
   logic          exc_flush;
   logic          div_block, div_in_valid, div_in_ready, div_signed;
   logic [DW-1:0] div_dividend, div_divisor;
   logic          div_out_valid;
   logic [DW-1:0] div_quotient, div_remainder;
   logic          div_res_valid;
   logic [DW-1:0] div_lo, div_hi;

   typedef struct {
      logic [DW-1:0] q;
      logic [DW-1:0] r;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int blk_cnt = 0;
   int hs_cnt = 0;
   int res_cnt = 0;
   int overlap_cnt = 0;
   logic ready_ctl;
   logic core_busy;
   int   core_cnt;

   always #5 clk = ~clk;

   div_ctrl #(.DW(DW)) dut (
      .clk(clk), .resetn(resetn),
      .es_valid(es_valid), .es_div_op(es_div_op), .es_div_signed(es_div_signed),
      .es_src1(es_src1), .es_src2(es_src2), .exc_flush(exc_flush),
      .div_block(div_block), .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
      .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_out_valid(div_out_valid), .div_quotient(div_quotient), .div_remainder(div_remainder),
      .div_res_valid(div_res_valid), .div_lo(div_lo), .div_hi(div_hi)
   );

   // Divider core: result pulse L cycles after the handshake cycle.
   assign div_in_ready = ready_ctl;
   always @(posedge clk) begin
      if (!resetn) begin
         core_busy     <= 1'b0;
         core_cnt      <= 0;
         div_out_valid <= 1'b0;
         div_quotient  <= '0;
         div_remainder <= '0;
      end else begin
         div_out_valid <= 1'b0;
         if (div_in_valid && div_in_ready) begin
            if (core_busy) overlap_cnt <= overlap_cnt + 1;
            core_busy <= 1'b1;
            core_cnt  <= L - 1;
            if (div_signed) begin
               div_quotient  <= $signed(div_dividend) / $signed(div_divisor);
               div_remainder <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
               div_quotient  <= div_dividend / div_divisor;
               div_remainder <= div_dividend % div_divisor;
            end
         end else if (core_busy) begin
            if (core_cnt == 1) begin
               div_out_valid <= 1'b1;
               core_busy     <= 1'b0;
            end else begin
               core_cnt <= core_cnt - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (div_block === 1'b1) blk_cnt++;
      if (div_in_valid === 1'b1 && div_in_ready === 1'b1) hs_cnt++;
      if (div_res_valid === 1'b1) res_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #3;
   endtask

   task automatic start_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] eq, input logic [DW-1:0] er, input bit push);
      exp_t e;
      @(negedge clk);
      es_valid      = 1'b1;
      es_div_op     = 1'b1;
      es_div_signed = sgn;
      es_src1       = a;
      es_src2       = b;
      exc_flush     = 1'b0;
      if (push) begin
         e.q = eq;
         e.r = er;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input int budget, input string name);
      exp_t e;
      bit got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (div_res_valid === 1'b1) begin
            got = 1;
            break;
         end
      end
      es_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_timeout: got no div_res_valid within %0d cycles, required one", name, budget);
      end else if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s_unexpected: got result lo=%h hi=%h, required none", name, div_lo, div_hi);
      end else begin
         e = sb.pop_front();
         $display("txn %s: lo=%h hi=%h (expected %h/%h)", name, div_lo, div_hi, e.q, e.r);
         if (div_lo !== e.q || div_hi !== e.r) begin
            errors++;
            $display("FAIL %s_result: got lo=%h hi=%h, required lo=%h hi=%h", name, div_lo, div_hi, e.q, e.r);
         end
         checks++;
         if (div_block !== 1'b0) begin
            errors++;
            $display("FAIL %s_block_in_done: got %b, required 0", name, div_block);
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      es_valid = 1'b0; es_div_op = 1'b0; es_div_signed = 1'b0;
      es_src1 = '0; es_src2 = '0; exc_flush = 1'b0; ready_ctl = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({div_in_valid, div_res_valid, div_signed, div_block} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got in_valid/res_valid/signed/block=%b, required 0000",
                  {div_in_valid, div_res_valid, div_signed, div_block});
      end
      checks++;
      if ({div_lo, div_hi, div_dividend, div_divisor} !== '0) begin
         errors++;
         $display("FAIL reset_data: got lo=%h hi=%h dd=%h dv=%h, required all 0",
                  div_lo, div_hi, div_dividend, div_divisor);
      end
      @(negedge clk);
      resetn = 1'b1;
      settle(2);
   endtask

   task automatic test_divu_basic();
      int b0 = blk_cnt, h0 = hs_cnt, r0 = res_cnt;
      start_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1);
      #1;
      checks++;
      if (div_block !== 1'b1) begin
         errors++;
         $display("FAIL divu_detect_block: got %b, required 1", div_block);
      end
      wait_done(40, "divu_100_7");
      @(negedge clk);
      #1;
      checks++;
      if (div_res_valid !== 1'b0 || div_lo !== 32'd14 || div_hi !== 32'd2) begin
         errors++;
         $display("FAIL divu_after_done: got res_valid=%b lo=%h hi=%h, required 0/0000000e/00000002",
                  div_res_valid, div_lo, div_hi);
      end
      #2;
      checks++;
      if (blk_cnt - b0 != L + 2) begin
         errors++;
         $display("FAIL divu_block_cycles: got %0d, required %0d", blk_cnt - b0, L + 2);
      end
      checks++;
      if (hs_cnt - h0 != 1 || res_cnt - r0 != 1) begin
         errors++;
         $display("FAIL divu_pulses: got handshakes=%0d results=%0d, required 1/1", hs_cnt - h0, res_cnt - r0);
      end
   endtask

   task automatic test_div_signed();
      start_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1);
      @(negedge clk);
      #1;
      checks++;
      if (div_signed !== 1'b1 || div_in_valid !== 1'b1 || div_dividend !== 32'hFFFF_FFF9) begin
         errors++;
         $display("FAIL div_signed_req: got signed=%b in_valid=%b dd=%h, required 1/1/fffffff9",
                  div_signed, div_in_valid, div_dividend);
      end
      wait_done(40, "div_m7_2");
      settle(1);
   endtask

   task automatic test_ready_stall();
      int b0 = blk_cnt, h0 = hs_cnt;
      ready_ctl = 1'b0;
      start_div(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (div_in_valid !== 1'b1 || div_dividend !== 32'd1000 || div_divisor !== 32'd33 || div_block !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold_c%0d: got in_valid=%b dd=%h dv=%h block=%b, required 1/000003e8/00000021/1",
                     c, div_in_valid, div_dividend, div_divisor, div_block);
         end
      end
      @(negedge clk);
      ready_ctl = 1'b1;
      #1;
      checks++;
      if (div_in_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_handshake: got in_valid=%b, required 1", div_in_valid);
      end
      wait_done(40, "divu_1000_33");
      settle(1);
      checks++;
      if (blk_cnt - b0 != L + 5 || hs_cnt - h0 != 1) begin
         errors++;
         $display("FAIL stall_counts: got block=%0d handshakes=%0d, required %0d/1", blk_cnt - b0, hs_cnt - h0, L + 5);
      end
   endtask

   task automatic test_flush_wait();
      int h0 = hs_cnt, r0 = res_cnt;
      start_div(1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      exc_flush = 1'b1;
      es_valid  = 1'b0;
      #1;
      checks++;
      if (div_block !== 1'b0) begin
         errors++;
         $display("FAIL flush_wait_block: got %b, required 0", div_block);
      end
      start_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1);
      #1;
      for (int c = 5; c <= 10; c++) begin
         if (c > 5) begin
            @(negedge clk);
            #1;
         end
         checks++;
         if (div_block !== 1'b1 || div_in_valid !== 1'b0 || div_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_c%0d: got block=%b in_valid=%b res_valid=%b, required 1/0/0",
                     c, div_block, div_in_valid, div_res_valid);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (div_in_valid !== 1'b1 || div_dividend !== 32'd9) begin
         errors++;
         $display("FAIL drain_relaunch: got in_valid=%b dd=%h, required 1/00000009", div_in_valid, div_dividend);
      end
      wait_done(40, "divu_9_3");
      settle(1);
      checks++;
      if (hs_cnt - h0 != 2 || res_cnt - r0 != 1) begin
         errors++;
         $display("FAIL drain_counts: got handshakes=%0d results=%0d, required 2/1", hs_cnt - h0, res_cnt - r0);
      end
   endtask

   task automatic test_flush_req();
      int h0 = hs_cnt, r0 = res_cnt;
      ready_ctl = 1'b0;
      start_div(1'b0, 32'd20, 32'd4, 32'd5, 32'd0, 0);
      @(negedge clk);
      exc_flush = 1'b1;
      es_valid  = 1'b0;
      #1;
      checks++;
      if (div_block !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_block: got %b, required 0", div_block);
      end
      @(negedge clk);
      exc_flush = 1'b0;
      ready_ctl = 1'b1;
      #1;
      checks++;
      if (div_in_valid !== 1'b0 || div_block !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_idle: got in_valid=%b block=%b, required 0/0", div_in_valid, div_block);
      end
      settle(12);
      checks++;
      if (hs_cnt - h0 != 0 || res_cnt - r0 != 0) begin
         errors++;
         $display("FAIL flush_req_nohs: got handshakes=%0d results=%0d, required 0/0", hs_cnt - h0, res_cnt - r0);
      end
      h0 = hs_cnt;
      r0 = res_cnt;
      start_div(1'b0, 32'd20, 32'd4, 32'd5, 32'd0, 0);
      @(negedge clk);
      exc_flush = 1'b1;
      es_valid  = 1'b0;
      @(negedge clk);
      exc_flush = 1'b0;
      #1;
      checks++;
      if (div_in_valid !== 1'b0 || div_block !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_drain: got in_valid=%b block=%b, required 0/0", div_in_valid, div_block);
      end
      settle(12);
      checks++;
      if (hs_cnt - h0 != 1 || res_cnt - r0 != 0 || core_busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_taken: got handshakes=%0d results=%0d busy=%b, required 1/0/0",
                  hs_cnt - h0, res_cnt - r0, core_busy);
      end
   endtask

   task automatic test_flush_done();
      int r0 = res_cnt;
      start_div(1'b0, 32'd30, 32'd6, 32'd5, 32'd0, 0);
      repeat (L + 1) @(negedge clk);
      @(negedge clk);
      exc_flush = 1'b1;
      es_valid  = 1'b0;
      #1;
      checks++;
      if (div_res_valid !== 1'b0 || div_block !== 1'b0) begin
         errors++;
         $display("FAIL flush_done: got res_valid=%b block=%b, required 0/0", div_res_valid, div_block);
      end
      @(negedge clk);
      exc_flush = 1'b0;
      settle(2);
      checks++;
      if (res_cnt - r0 != 0) begin
         errors++;
         $display("FAIL flush_done_pulses: got %0d results, required 0", res_cnt - r0);
      end
   endtask

   task automatic test_reset_wait();
      int b0;
      start_div(1'b1, 32'd77, 32'd7, 32'd11, 32'd0, 0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      resetn   = 1'b0;
      es_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++;
      if ({div_in_valid, div_res_valid, div_signed, div_block} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_wait_flags: got in_valid/res_valid/signed/block=%b, required 0000",
                  {div_in_valid, div_res_valid, div_signed, div_block});
      end
      checks++;
      if ({div_lo, div_hi, div_dividend, div_divisor} !== '0) begin
         errors++;
         $display("FAIL rst_wait_data: got lo=%h hi=%h dd=%h dv=%h, required all 0",
                  div_lo, div_hi, div_dividend, div_divisor);
      end
      settle(1);
      b0 = blk_cnt;
      start_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1);
      wait_done(40, "divu_50_5");
      settle(1);
      checks++;
      if (blk_cnt - b0 != L + 2) begin
         errors++;
         $display("FAIL rst_after_block: got %0d, required %0d", blk_cnt - b0, L + 2);
      end
   endtask

   task automatic test_back_to_back();
      int h0 = hs_cnt, r0 = res_cnt;
      start_div(1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1);
      wait_done(40, "b2b_first");
      start_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1);
      wait_done(40, "b2b_second");
      settle(1);
      checks++;
      if (hs_cnt - h0 != 2 || res_cnt - r0 != 2) begin
         errors++;
         $display("FAIL b2b_counts: got handshakes=%0d results=%0d, required 2/2", hs_cnt - h0, res_cnt - r0);
      end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_div_signed();
      test_ready_stall();
      test_flush_wait();
      test_flush_req();
      test_flush_done();
      test_reset_wait();
      test_back_to_back();
      checks++;
      if (sb.size() != 0 || overlap_cnt != 0) begin
         errors++;
         $display("FAIL final_state: got pending=%0d overlaps=%0d, required 0/0", sb.size(), overlap_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage sequencer for the multi-cycle divider. It detects a DIV/DIVU in the execute stage and launches the operands into the external divider core over a valid/ready handshake. It holds the pipeline through `div_block` until the quotient and remainder return, then presents them for one cycle. `div_block` drives the hazard unit's execute stall. If the operation is flushed by an exception or ERET mid-flight, the block drains and discards the divider's in-flight result.

## Interface
Parameters:
- `DW`, 32, operand/result width.

Ports:
- `clk` in 1: clock, single domain.
- `resetn` in 1: reset, synchronous, active-low.
- `es_valid` in 1: execute stage holds a valid instruction.
- `es_div_op` in 1: that instruction is DIV/DIVU.
- `es_div_signed` in 1: 1 = DIV, 0 = DIVU.
- `es_src1` in DW: dividend.
- `es_src2` in DW: divisor.
- `exc_flush` in 1: exception/ERET flush from the hazard unit.
- `div_block` out 1: execute-stage stall request to the hazard unit.
- `div_in_valid` out 1: operands valid to the divider core.
- `div_in_ready` in 1: divider core accepts operands.
- `div_signed` out 1: latched signedness to the core.
- `div_dividend` out DW: latched dividend.
- `div_divisor` out DW: latched divisor.
- `div_out_valid` in 1: core result valid, a single-cycle pulse.
- `div_quotient` in DW: core quotient.
- `div_remainder` in DW: core remainder.
- `div_res_valid` out 1: result valid to the execute stage (HI/LO write).
- `div_lo` out DW: registered quotient.
- `div_hi` out DW: registered remainder.

## Operation
- `new_div` = `es_valid & es_div_op & !exc_flush`.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - on `new_div`, latch `es_src1`, `es_src2` and `es_div_signed`, then go to REQ.
  - otherwise stay in IDLE.
- REQ: `div_in_valid`=1 and operands are held stable.
  - `exc_flush & div_in_ready`: go to DRAIN (handshake taken).
  - `exc_flush & !div_in_ready`: go to IDLE (nothing issued).
  - `div_in_ready`: go to WAIT.
  - otherwise stay in REQ.
- WAIT:
  - `div_out_valid & !exc_flush`: latch quotient into `div_lo` and remainder into `div_hi`, go to DONE.
  - `div_out_valid & exc_flush`: discard the result, go to IDLE.
  - `exc_flush`: go to DRAIN.
- DONE: `div_res_valid`=1 and the next state is always IDLE.
  - Downstream stages never stall, so the execute stage retires the instruction this cycle.
  - `exc_flush` in DONE: `div_res_valid` is forced 0 and the state goes to IDLE.
- DRAIN: wait for `div_out_valid`, discard the result, go to IDLE.
  - A new divide arriving during DRAIN is only blocked. It is launched from IDLE afterwards.
- `div_block` = `!exc_flush & ((IDLE & new_div) | REQ | WAIT | (DRAIN & es_valid & es_div_op))`. This is combinational.
- Only one operation is in the core at a time. A second `div_in_valid` is never raised before the outstanding `div_out_valid`.
- Divide-by-zero: the core output passes through unchanged; architecturally undefined. Signed overflow (0x80000000 / -1) is handled the same way.

## Timing
- Reset values (`resetn`=0 at a clock edge) are:
  - state = IDLE.
  - `div_in_valid`, `div_res_valid` = 0.
  - `div_lo`, `div_hi`, `div_dividend`, `div_divisor` = 0.
  - `div_signed` = 0.
  - `div_block` = 0 unless `new_div`.
- Reset mid-operation abandons the transaction. The core is reset by the same `resetn`, so no drain is needed.
- Latency, with core latency L cycles from handshake to `div_out_valid` and `div_in_ready` high:
  - cycle 0: IDLE, detect. `div_block`=1.
  - cycle 1: REQ handshake.
  - cycle 1+L: WAIT, `div_out_valid`.
  - cycle 2+L: DONE, `div_block`=0, `div_res_valid`=1.
  - `div_block` is high for exactly L+2 cycles.
- Each cycle of `div_in_ready`=0 in REQ adds one cycle.
- `div_res_valid` is a one-cycle pulse. `div_lo`/`div_hi` hold their value until the next capture.
- `exc_flush` takes effect in the same cycle: `div_block`=0 and `div_res_valid`=0 combinationally.

## Test plan
- DIVU 100/7, L=8, ready=1:
  - `div_block` high for 10 cycles.
  - DONE shows `div_lo`=14, `div_hi`=2, `div_res_valid` pulse of 1 cycle.
- DIV -7/2 signed:
  - `div_signed`=1.
  - result `div_lo`=0xFFFFFFFD, `div_hi`=0xFFFFFFFF.
- `div_in_ready` held 0 for 3 cycles in REQ:
  - `div_in_valid` and operands stay stable.
  - `div_block` high for L+5 cycles.
  - exactly one handshake occurs.
- `exc_flush` in WAIT at cycle 4, then a new DIVU 9/3 in the following cycle:
  - DRAIN, with the old result discarded (no `div_res_valid`).
  - the new divide stays blocked until the old `div_out_valid`, then launches.
  - result 3/0.
- `exc_flush` in REQ with `div_in_ready`=0:
  - goes to IDLE, no handshake.
  - with `div_in_ready`=1 instead: goes to DRAIN and waits for the result.
- `resetn`=0 during WAIT:
  - next cycle all outputs are at reset values and the state is IDLE.
  - a following DIVU 50/5 completes with `div_lo`=10, `div_hi`=0.
